// File: rtl/instruction_fetch_unit.sv
// Instruction fetch unit: single-outstanding memory requests feeding a 2-entry {pc, instr} buffer,
// with branch redirect flushing and discard of a stale in-flight response.
module instruction_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        if_valid,
  input  logic        id_ready,
  output logic [31:0] if_instr,
  output logic [31:0] if_pc,
  output logic [1:0]  buf_count
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_REQ     = 2'd1,
    ST_DISCARD = 2'd2
  } state_t;

  state_t      state_r;
  state_t      state_next_s;
  logic [31:0] fetch_pc_r;
  logic [31:0] fetch_pc_next_s;
  logic [31:0] saved_pc_r;
  logic [31:0] saved_pc_next_s;
  logic [31:0] pc_mem_r    [2];
  logic [31:0] instr_mem_r [2];
  logic        rd_ptr_r;
  logic        wr_ptr_r;
  logic [1:0]  count_r;
  logic [1:0]  count_next_s;
  logic        push_s;
  logic        pop_s;
  logic [31:0] redirect_tgt_s;

  assign redirect_tgt_s = {redirect_pc[31:2], 2'b00};

  assign imem_req  = (state_r == ST_REQ) || (state_r == ST_DISCARD);
  assign imem_addr = fetch_pc_r;
  assign if_valid  = (count_r != 2'd0) && !redirect;
  assign if_instr  = instr_mem_r[rd_ptr_r];
  assign if_pc     = pc_mem_r[rd_ptr_r];
  assign buf_count = count_r;

  // Buffer push/pop qualification and next occupancy.
  always_comb begin
    push_s       = 1'b0;
    pop_s        = 1'b0;
    count_next_s = count_r;
    if ((state_r == ST_REQ) && imem_ready && !redirect && (count_r != 2'd2)) begin
      push_s = 1'b1;
    end else begin
      push_s = 1'b0;
    end
    pop_s = if_valid && id_ready;
    if (redirect) begin
      count_next_s = 2'd0;
    end else begin
      case ({push_s, pop_s})
        2'b10:   count_next_s = count_r + 2'd1;
        2'b01:   count_next_s = count_r - 2'd1;
        default: count_next_s = count_r;
      endcase
    end
  end

  // Next state, fetch address and saved redirect target.
  always_comb begin
    state_next_s    = state_r;
    fetch_pc_next_s = fetch_pc_r;
    saved_pc_next_s = saved_pc_r;
    if (redirect) begin
      // An unfinished request must run to completion on its stale address first.
      if ((state_r != ST_IDLE) && !imem_ready) begin
        state_next_s    = ST_DISCARD;
        saved_pc_next_s = redirect_tgt_s;
      end else begin
        state_next_s    = ST_REQ;
        fetch_pc_next_s = redirect_tgt_s;
      end
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (count_next_s < 2'd2) begin
            state_next_s = ST_REQ;
          end else begin
            state_next_s = ST_IDLE;
          end
        end
        ST_REQ: begin
          if (push_s) begin
            fetch_pc_next_s = fetch_pc_r + 32'd4;
            if (count_next_s < 2'd2) begin
              state_next_s = ST_REQ;
            end else begin
              state_next_s = ST_IDLE;
            end
          end else if (imem_ready) begin
            // Completion with no room: refetch the same address once space frees.
            state_next_s = ST_IDLE;
          end else begin
            state_next_s = ST_REQ;
          end
        end
        ST_DISCARD: begin
          if (imem_ready) begin
            state_next_s    = ST_REQ;
            fetch_pc_next_s = saved_pc_r;
          end else begin
            state_next_s = ST_DISCARD;
          end
        end
        default: begin
          state_next_s = ST_REQ;
        end
      endcase
    end
  end

  // Control state, fetch address, occupancy and buffer pointers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r    <= ST_REQ;
      fetch_pc_r <= RESET_PC;
      saved_pc_r <= RESET_PC;
      count_r    <= 2'd0;
      rd_ptr_r   <= 1'b0;
      wr_ptr_r   <= 1'b0;
    end else begin
      state_r    <= state_next_s;
      fetch_pc_r <= fetch_pc_next_s;
      saved_pc_r <= saved_pc_next_s;
      count_r    <= count_next_s;
      if (redirect) begin
        rd_ptr_r <= 1'b0;
        wr_ptr_r <= 1'b0;
      end else begin
        if (push_s) begin
          wr_ptr_r <= ~wr_ptr_r;
        end
        if (pop_s) begin
          rd_ptr_r <= ~rd_ptr_r;
        end
      end
    end
  end

  // Buffer storage.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < 2; i++) begin
        pc_mem_r[i]    <= 32'h0000_0000;
        instr_mem_r[i] <= 32'h0000_0000;
      end
    end else if (push_s) begin
      pc_mem_r[wr_ptr_r]    <= fetch_pc_r;
      instr_mem_r[wr_ptr_r] <= imem_rdata;
    end
  end

endmodule
